ft245_fifo_bridge: RTL



---
 rtl/ft245_fifo_bridge.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ft245_fifo_bridge.sv
// ft245_fifo_bridge: FT245-style asynchronous parallel-FIFO bridge.
// Synchronises the device flags, times the rd/wr strobes with round-robin
// RX/TX arbitration, and buffers both directions in DEPTH-entry FIFOs with
// valid/ready streams on the SoC side.
// Ports:
//   clk, reset                 sole clock, synchronous active-high reset
//   ft_data_i/_o/_oe           FT245 data pad (tristate resolved at the pad)
//   ft_txe_n, ft_rxf_n         asynchronous device flags, active low
//   ft_rd_n, ft_wr_n           registered strobes, active low
//   tx_data/valid/ready        SoC -> host stream into the TX FIFO
//   rx_data/valid/ready        host -> SoC first-word fall-through stream
//   tx_level, rx_level         FIFO occupancy
module ft245_fifo_bridge #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned RD_CYCLES   = 3,
   parameter int unsigned WR_CYCLES   = 2,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        ft_data_i,
   output logic [DATA_W-1:0]        ft_data_o,
   output logic                     ft_data_oe,
   input  logic                     ft_txe_n,
   input  logic                     ft_rxf_n,
   output logic                     ft_rd_n,
   output logic                     ft_wr_n,
   input  logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic [DATA_W-1:0]        rx_data,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [$clog2(DEPTH):0]   tx_level,
   output logic [$clog2(DEPTH):0]   rx_level
);

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam int unsigned LW         = AW + 1;
   localparam int unsigned REC_CYCLES = SYNC_STAGES + GAP_CYCLES;
   localparam int unsigned CNT_MAX    =
      (RD_CYCLES > WR_CYCLES) ? ((RD_CYCLES > REC_CYCLES) ? RD_CYCLES : REC_CYCLES)
                              : ((WR_CYCLES > REC_CYCLES) ? WR_CYCLES : REC_CYCLES);
   localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR_SETUP,
      S_WR,
      S_WR_HOLD,
      S_RECOVER
   } state_t;

   // ---------------------------------------------------------------- flags
   logic [SYNC_STAGES-1:0] txe_sync;
   logic [SYNC_STAGES-1:0] rxf_sync;
   logic                   s_txe;
   logic                   s_rxf;

   // Flag synchronisers; reset to 1 so the device reads as not ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         txe_sync <= '1;
         rxf_sync <= '1;
      end else begin
         txe_sync <= {txe_sync[SYNC_STAGES-2:0], ft_txe_n};
         rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], ft_rxf_n};
      end
   end

   assign s_txe = !txe_sync[SYNC_STAGES-1];
   assign s_rxf = !rxf_sync[SYNC_STAGES-1];

   // -------------------------------------------------------------- TX FIFO
   logic [DATA_W-1:0] tx_mem [DEPTH];
   logic [AW:0]       tx_wp, tx_rp;
   logic              tx_full, tx_empty;
   logic              tx_push, tx_pop;
   logic              tx_wr_en, tx_rd_en;

   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign tx_empty = (tx_wp == tx_rp);
   assign tx_level = LW'(tx_wp - tx_rp);
   assign tx_ready = !tx_full && !reset;
   assign tx_push  = tx_valid && tx_ready;
   // A simultaneous push and pop is allowed even at the full/empty corner.
   assign tx_wr_en = tx_push && (!tx_full || tx_pop);
   assign tx_rd_en = tx_pop && (!tx_empty || tx_push);

   always_ff @(posedge clk) begin
      if (tx_wr_en) tx_mem[tx_wp[AW-1:0]] <= tx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_wr_en) tx_wp <= tx_wp + LW'(1);
         if (tx_rd_en) tx_rp <= tx_rp + LW'(1);
      end
   end

   // -------------------------------------------------------------- RX FIFO
   logic [DATA_W-1:0] rx_mem [DEPTH];
   logic [AW:0]       rx_wp, rx_rp;
   logic              rx_full, rx_empty;
   logic              rx_push, rx_pop;
   logic              rx_wr_en, rx_rd_en;

   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_level = LW'(rx_wp - rx_rp);
   assign rx_valid = !rx_empty;
   assign rx_data  = rx_mem[rx_rp[AW-1:0]];
   assign rx_pop   = rx_valid && rx_ready;
   assign rx_wr_en = rx_push && !reset && (!rx_full || rx_pop);
   assign rx_rd_en = rx_pop && (!rx_empty || rx_push);

   // The pad byte is captured straight into the FIFO on the final RD edge.
   always_ff @(posedge clk) begin
      if (rx_wr_en) rx_mem[rx_wp[AW-1:0]] <= ft_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_wr_en) rx_wp <= rx_wp + LW'(1);
         if (rx_rd_en) rx_rp <= rx_rp + LW'(1);
      end
   end

   // ------------------------------------------------------------------ FSM
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              last_was_rd, last_was_rd_n;
   logic              rd_n_n, wr_n_n, oe_n;
   logic [DATA_W-1:0] data_o_n;
   logic              can_rd, can_wr, go_rd, go_wr;

   // RECOVER guarantees no byte is in flight while deciding in IDLE.
   assign can_rd = s_rxf && (rx_level <= LW'(DEPTH - 1));
   assign can_wr = s_txe && !tx_empty;
   assign go_rd  = can_rd && (!can_wr || !last_was_rd);
   assign go_wr  = can_wr && !go_rd;

   // State and pad-side registers; strobes are the registered next values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         last_was_rd <= 1'b0;
         ft_rd_n     <= 1'b1;
         ft_wr_n     <= 1'b1;
         ft_data_oe  <= 1'b0;
         ft_data_o   <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         last_was_rd <= last_was_rd_n;
         ft_rd_n     <= rd_n_n;
         ft_wr_n     <= wr_n_n;
         ft_data_oe  <= oe_n;
         ft_data_o   <= data_o_n;
      end
   end

   // Next state; the pad values computed here apply during the next state.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      last_was_rd_n = last_was_rd;
      rd_n_n        = 1'b1;
      wr_n_n        = 1'b1;
      oe_n          = 1'b0;
      data_o_n      = ft_data_o;
      tx_pop        = 1'b0;
      rx_push       = 1'b0;

      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (go_rd) begin
               state_n = S_RD;
               rd_n_n  = 1'b0;
            end else if (go_wr) begin
               state_n  = S_WR_SETUP;
               tx_pop   = 1'b1;
               data_o_n = tx_mem[tx_rp[AW-1:0]];
               oe_n     = 1'b1;
            end
         end
         S_RD: begin
            if (cnt == CNT_W'(RD_CYCLES - 1)) begin
               rx_push       = 1'b1;
               state_n       = S_RECOVER;
               cnt_n         = '0;
               last_was_rd_n = 1'b1;
            end else begin
               cnt_n  = cnt + CNT_W'(1);
               rd_n_n = 1'b0;
            end
         end
         S_WR_SETUP: begin
            state_n = S_WR;
            cnt_n   = '0;
            wr_n_n  = 1'b0;
            oe_n    = 1'b1;
         end
         S_WR: begin
            oe_n = 1'b1;
            if (cnt == CNT_W'(WR_CYCLES - 1)) begin
               state_n = S_WR_HOLD;
            end else begin
               cnt_n  = cnt + CNT_W'(1);
               wr_n_n = 1'b0;
            end
         end
         S_WR_HOLD: begin
            state_n       = S_RECOVER;
            cnt_n         = '0;
            last_was_rd_n = 1'b0;
         end
         S_RECOVER: begin
            if (cnt == CNT_W'(REC_CYCLES - 1)) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule
